uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 20000: maximum number of cycles in SEND before the frame is abandoned.
REQ-002 clk  input  1  clock; all logic is sampled on the rising edge.
REQ-003 rst  input  1  reset: synchronous, active-high.
REQ-004 req  input  4  per-requester byte-pending flag; req[i] is held high until req_ack[i] pulses.
REQ-005 req_data  input  32  byte for requester i at [8i+7:8i]; stable while req[i] is high.
REQ-006 req_last  input  4  req_last[i]=1 marks the current byte as the final byte of requester i's message.
REQ-007 req_ack  output  4  one-cycle pulse: requester i's byte has been transmitted.
REQ-008 tx_send  output  1  send strobe to the UART transmitter.
REQ-009 tx_data  output  8  byte to the UART transmitter; registered.
REQ-010 tx_done  input  1  transmitter stop-state flag; high after the frame and until tx_send falls.
REQ-011 grant_id  output  2  index of the requester currently granted.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 err  output  1  sticky timeout flag; cleared only by rst.

Function
REQ-014 The FSM states SHALL be IDLE, LOAD, SEND and RELEASE.
REQ-015 IDLE, lock clear: SHALL select the first req[i] set, scanning round-robin starting at rr_ptr; if any req is set, go to LOAD.
REQ-016 IDLE, lock set: SHALL consider only the locked requester; other requests wait even if asserted.
REQ-017 LOAD (1 cycle): SHALL latch req_data byte and req_last bit of grant_id into tx_data and last_q, then go to SEND.
REQ-018 SEND: tx_send SHALL be 1, and tx_data SHALL stay constant.
REQ-019 SEND, on a cycle with tx_done=1: next cycle tx_send=0, req_ack[grant_id]=1 for exactly one cycle, go to RELEASE.
REQ-020 On ack with last_q=1: clear the lock and set rr_ptr=grant_id+1 (mod 4, 2-bit wrap).
REQ-021 On ack with last_q=0: set the lock to grant_id; rr_ptr is unchanged.
REQ-022 RELEASE: SHALL hold tx_send=0 until tx_done=0 is sampled, then go to IDLE; minimum 1 cycle.
REQ-023 Consequence: tx_send never rises while tx_done=1, and there are at least 2 cycles of tx_send low between frames.
REQ-024 Timeout: SEND lasting TIMEOUT_CYCLES cycles without tx_done SHALL force tx_send=0, set err, clear the lock, give no req_ack, and go to RELEASE.
REQ-025 Timeout: rr_ptr SHALL advance past the failed requester; the byte is dropped and the requester keeps req high to retry.
REQ-026 req[grant_id] deasserted during LOAD/SEND SHALL NOT abort the frame; the ack is still issued.
REQ-027 grant_id SHALL update only on the IDLE-to-LOAD transition.
REQ-028 No combinational path from req/req_data to tx_send/tx_data.
REQ-029 Timeout counter: 15 bits minimum, cleared on every entry to SEND.

Reset
REQ-030 On rst, next edge: state=IDLE, tx_send=0, tx_data=8'h00, req_ack=0, grant_id=0, rr_ptr=0, lock clear, busy=0, err=0, timeout counter=0.
REQ-031 rst mid-frame SHALL drop tx_send on the next edge with no ack issued; the shared rst also resets the transmitter.

Verification
REQ-032 Single byte: req=4'b0100, byte2=8'hA5, last=1; model done 870 cycles after send rises -> tx_data=A5, one req_ack[2] pulse, rr_ptr=3, busy falls.
REQ-033 Round-robin: req=4'b1111 held, all last=1, rr_ptr=0 -> grants in order 0,1,2,3,0; each ack is 1 cycle; tx_send low at least 2 cycles between frames.
REQ-034 Message lock: req0 sends 3 bytes 11,22,33 (last on 33) while req1 is held high -> byte order 11,22,33 then req1's byte; grant_id=0 throughout the message.
REQ-035 Timeout: TIMEOUT_CYCLES=50, tx_done tied 0, req=4'b0001 -> tx_send falls after 50 SEND cycles, err=1 and stays 1, no ack, rr_ptr=1.
REQ-036 Reset mid-frame: rst pulsed 100 cycles into SEND -> next edge tx_send=0, busy=0, err=0, no ack; resumes normally when req is reasserted.
REQ-037 Done held high: tx_done stays 1 for 5 cycles after tx_send falls -> controller stays in RELEASE for those cycles; next tx_send rises no earlier than 2 cycles after done falls.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Four-requester byte arbiter in front of a UART transmitter.
// Round-robin grant with per-message lock, done/timeout handshake with the transmitter.
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_last,
  output logic [3:0]  req_ack,
  output logic        tx_send,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic [1:0]  grant_id,
  output logic        busy,
  output logic        err
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 15) ? $clog2(TIMEOUT_CYCLES) : 15;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    SEND    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e           state_q,   state_d;
  logic [1:0]       grant_q,   grant_d;
  logic [1:0]       rr_q,      rr_d;
  logic [1:0]       lock_id_q, lock_id_d;
  logic             lock_q,    lock_d;
  logic             last_q,    last_d;
  logic             err_q,     err_d;
  logic             tx_send_q, tx_send_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [3:0]       ack_q,     ack_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  logic       pick_valid;
  logic [1:0] pick_id;

  // While a message is in flight only its owner may win; otherwise the
  // lowest offset from rr_q wins, so the loop runs from the far end down.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = rr_q;
    if (lock_q) begin
      pick_valid = req[lock_id_q];
      pick_id    = lock_id_q;
    end else begin
      for (int k = 3; k >= 0; k--) begin
        if (req[rr_q + 2'(k)]) begin
          pick_valid = 1'b1;
          pick_id    = rr_q + 2'(k);
        end
      end
    end
  end

  always_comb begin
    // NOTE: every *_d gets its hold value first so no path through the case leaves one unassigned (no latches).
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    lock_id_d = lock_id_q;
    lock_d    = lock_q;
    last_d    = last_q;
    err_d     = err_q;
    tx_data_d = tx_data_q;
    ack_d     = 4'b0000;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_id;
          state_d = LOAD;
        end
      end
      LOAD: begin
        tx_data_d = req_data[{grant_q, 3'b000} +: 8];
        last_d    = req_last[grant_q];
        cnt_d     = '0;
        state_d   = SEND;
      end
      SEND: begin
        if (tx_done) begin
          ack_d[grant_q] = 1'b1;
          if (last_q) begin
            lock_d = 1'b0;
            rr_d   = grant_q + 2'd1;
          end else begin
            lock_d    = 1'b1;
            lock_id_d = grant_q;
          end
          state_d = RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          // Abandoned frame: no ack, requester keeps req high and retries later.
          err_d   = 1'b1;
          lock_d  = 1'b0;
          rr_d    = grant_q + 2'd1;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    tx_send_d = (state_d == SEND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 2'd0;
      rr_q      <= 2'd0;
      lock_id_q <= 2'd0;
      lock_q    <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
      tx_send_q <= 1'b0;
      tx_data_q <= 8'h00;
      ack_q     <= 4'b0000;
      cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge value of every other flop.
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      lock_id_q <= lock_id_d;
      lock_q    <= lock_d;
      last_q    <= last_d;
      err_q     <= err_d;
      tx_send_q <= tx_send_d;
      tx_data_q <= tx_data_d;
      ack_q     <= ack_d;
      cnt_q     <= cnt_d;
    end
  end

  assign req_ack  = ack_q;
  assign tx_send  = tx_send_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);
  assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: per-requester byte queues and a round-robin/lock model
// predict every grant, byte and ack; a behavioural transmitter drives tx_done.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } item_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ack;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err;

  logic        t_rst;
  logic [3:0]  t_req;
  logic [31:0] t_req_data;
  logic [3:0]  t_req_last;
  logic [3:0]  t_req_ack;
  logic        t_tx_send;
  logic [7:0]  t_tx_data;
  logic        t_tx_done;
  logic [1:0]  t_grant_id;
  logic        t_busy;
  logic        t_err;

  uart_tx_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack), .tx_send(tx_send), .tx_data(tx_data), .tx_done(tx_done),
    .grant_id(grant_id), .busy(busy), .err(err)
  );

  uart_tx_arbiter #(.TIMEOUT_CYCLES(50)) dut_to (
    .clk(clk), .rst(t_rst), .req(t_req), .req_data(t_req_data), .req_last(t_req_last),
    .req_ack(t_req_ack), .tx_send(t_tx_send), .tx_data(t_tx_data), .tx_done(t_tx_done),
    .grant_id(t_grant_id), .busy(t_busy), .err(t_err)
  );

  int checks   = 0;
  int failures = 0;

  item_t      q[4][$];
  int         m_rr;
  bit         m_lock;
  int         m_lock_id;
  int         grant_log[$];
  logic [7:0] byte_log[$];

  int   done_lat;
  int   done_hold;
  int   send_cnt;
  int   hold_cnt;
  int   since_fall;
  logic done_at_edge;

  // One clock step; the transmitter raises done done_lat cycles into a frame
  // (0 = never) and keeps it up done_hold cycles after tx_send falls.
  task automatic tick();
    @(negedge clk);
    done_at_edge = tx_done;
    if (rst) begin
      tx_done  = 1'b0;
      send_cnt = 0;
      hold_cnt = 0;
    end else if (tx_send) begin
      send_cnt++;
      hold_cnt = 0;
      if (done_lat > 0 && send_cnt >= done_lat) tx_done = 1'b1;
    end else begin
      send_cnt = 0;
      if (tx_done) begin
        if (hold_cnt >= done_hold) tx_done = 1'b0;
        else hold_cnt++;
      end
    end
    if (done_at_edge && !tx_done) since_fall = 0;
    else if (!tx_done && since_fall < 1000) since_fall++;
  endtask

  task automatic push_item(input int i, input logic [7:0] d, input logic l);
    item_t it;
    it.d = d;
    it.l = l;
    q[i].push_back(it);
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < 4; i++) begin
      if (q[i].size() > 0) begin
        req[i]            = 1'b1;
        req_data[8*i +: 8] = q[i][0].d;
        req_last[i]       = q[i][0].l;
      end else begin
        req[i]      = 1'b0;
        req_last[i] = 1'b0;
      end
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < 4; i++) n += q[i].size();
    return n;
  endfunction

  function automatic int model_pick();
    if (m_lock) return m_lock_id;
    for (int k = 0; k < 4; k++)
      if (q[(m_rr + k) % 4].size() > 0) return (m_rr + k) % 4;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) q[i].delete();
    drive_reqs();
    tick();
    tick();
    rst       = 1'b0;
    m_rr      = 0;
    m_lock    = 1'b0;
    m_lock_id = 0;
    grant_log.delete();
    byte_log.delete();
  endtask

  // Runs queued traffic against the model until max_acks acks, empty queues, or budget.
  task automatic run_traffic(input string tag, input int max_acks, input int budget);
    int         cyc;
    int         acks;
    int         cur;
    int         low_run;
    int         exp_id;
    logic       prev_send;
    logic [7:0] frame_byte;
    bit         data_moved;
    item_t      it;
    cyc        = 0;
    acks       = 0;
    cur        = -1;
    low_run    = 99;
    prev_send  = tx_send;
    frame_byte = tx_data;
    data_moved = 1'b0;
    while (pending() > 0 && acks < max_acks && cyc < budget) begin
      tick();
      cyc++;
      if (tx_send && !prev_send) begin
        exp_id = model_pick();
        checks++;
        if (exp_id < 0 || grant_id !== 2'(exp_id)) begin
          failures++;
          $display("FAIL %s grant: got %0d expected %0d", tag, grant_id, exp_id);
        end
        checks++;
        if (exp_id >= 0 && tx_data !== q[exp_id][0].d) begin
          failures++;
          $display("FAIL %s tx_data: got %h expected %h", tag, tx_data, q[exp_id][0].d);
        end
        checks++;
        if (low_run < 2 || done_at_edge !== 1'b0) begin
          failures++;
          $display("FAIL %s frame_gap: low cycles %0d done %b, expected >=2 and 0", tag, low_run, done_at_edge);
        end
        cur        = exp_id;
        frame_byte = tx_data;
        data_moved = 1'b0;
        grant_log.push_back(int'(grant_id));
        byte_log.push_back(tx_data);
      end
      if (tx_send && tx_data !== frame_byte) data_moved = 1'b1;
      if (req_ack !== 4'b0000) begin
        checks++;
        if (cur < 0 || req_ack !== (4'b0001 << cur) || data_moved) begin
          failures++;
          $display("FAIL %s ack: got %b for grant %0d (data moved %0d)", tag, req_ack, cur, data_moved);
        end
        if (cur >= 0) begin
          it = q[cur].pop_front();
          if (it.l) begin
            m_lock = 1'b0;
            m_rr   = (cur + 1) % 4;
          end else begin
            m_lock    = 1'b1;
            m_lock_id = cur;
          end
        end
        cur = -1;
        acks++;
        drive_reqs();
      end
      low_run   = tx_send ? 0 : low_run + 1;
      prev_send = tx_send;
    end
    checks++;
    if (cyc >= budget) begin
      failures++;
      $display("FAIL %s budget: %0d cycles used, %0d bytes still pending", tag, cyc, pending());
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req        = 4'hF;
    req_data   = $urandom;
    req_last   = 4'hF;
    t_rst      = 1'b1;
    t_req      = 4'hF;
    t_req_data = $urandom;
    t_req_last = 4'hF;
    tick();
    tick();
    tick();
    checks++;
    if (tx_send !== 1'b0) begin failures++; $display("FAIL reset tx_send: got %b expected 0", tx_send); end
    checks++;
    if (tx_data !== 8'h00) begin failures++; $display("FAIL reset tx_data: got %h expected 00", tx_data); end
    checks++;
    if (req_ack !== 4'b0000) begin failures++; $display("FAIL reset req_ack: got %b expected 0000", req_ack); end
    checks++;
    if (grant_id !== 2'd0) begin failures++; $display("FAIL reset grant_id: got %0d expected 0", grant_id); end
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset busy/err: got %b/%b expected 0/0", busy, err); end
    checks++;
    if ({t_tx_send, t_busy, t_err, t_req_ack} !== 7'd0) begin
      failures++;
      $display("FAIL reset timeout_dut: got send %b busy %b err %b ack %b expected all 0", t_tx_send, t_busy, t_err, t_req_ack);
    end
    t_rst = 1'b0;
    t_req = 4'h0;
    do_reset();
  endtask

  task automatic test_single_byte();
    do_reset();
    done_lat  = 870;
    done_hold = 0;
    push_item(2, 8'hA5, 1'b1);
    drive_reqs();
    run_traffic("single", 1, 2000);
    checks++;
    if (byte_log.size() != 1 || grant_log[0] != 2 || byte_log[0] !== 8'hA5) begin
      failures++;
      $display("FAIL single frame: got %0d frames first grant %0d byte %h expected 1 frame grant 2 byte a5",
               byte_log.size(), grant_log[0], byte_log[0]);
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL single busy_falls: got %b expected 0", busy); end
    done_lat = 4;
    push_item(0, 8'h01, 1'b1);
    push_item(1, 8'h02, 1'b1);
    push_item(3, 8'h03, 1'b1);
    drive_reqs();
    run_traffic("single_rr", 3, 300);
    checks++;
    if (grant_log.size() != 4 || grant_log[1] != 3 || grant_log[2] != 0 || grant_log[3] != 1) begin
      failures++;
      $display("FAIL single rr_after: got grants %p expected 2,3,0,1", grant_log);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    done_lat  = $urandom_range(3, 10);
    done_hold = 0;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) push_item(i, 8'($urandom), 1'b1);
    drive_reqs();
    run_traffic("rr", 8, 2000);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (k >= grant_log.size() || grant_log[k] != k % 4) begin
        failures++;
        $display("FAIL rr order[%0d]: got grants %p expected %0d at this slot", k, grant_log, k % 4);
      end
    end
  endtask

  task automatic test_message_lock();
    logic [7:0] exp_b[6];
    int         exp_g[6];
    do_reset();
    done_lat  = 6;
    done_hold = 0;
    push_item(2, 8'hEE, 1'b1);
    drive_reqs();
    run_traffic("lock_pre", 1, 500);
    push_item(0, 8'h11, 1'b0);
    push_item(0, 8'h22, 1'b0);
    push_item(0, 8'h33, 1'b1);
    push_item(1, 8'h44, 1'b1);
    drive_reqs();
    run_traffic("lock_a", 1, 500);
    // Requester 3 sits between rr_ptr and requester 0, so only the lock keeps it out.
    push_item(3, 8'h55, 1'b1);
    drive_reqs();
    run_traffic("lock_b", 4, 2000);
    exp_b = '{8'hEE, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    exp_g = '{2, 0, 0, 0, 1, 3};
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= byte_log.size() || byte_log[k] !== exp_b[k] || grant_log[k] != exp_g[k]) begin
        failures++;
        $display("FAIL lock order[%0d]: got bytes %p grants %p expected byte %h grant %0d",
                 k, byte_log, grant_log, exp_b[k], exp_g[k]);
      end
    end
  endtask

  task automatic test_timeout();
    int   high;
    int   acks;
    int   cyc;
    bit   fell;
    bit   rose;
    t_rst      = 1'b1;
    t_req      = 4'b0000;
    t_req_data = 32'h0;
    t_req_last = 4'b0000;
    tick();
    tick();
    t_rst      = 1'b0;
    t_req      = 4'b0001;
    t_req_data = 32'h0000_005A;
    t_req_last = 4'b0001;
    high = 0; acks = 0; cyc = 0; fell = 1'b0;
    while (!fell && cyc < 300) begin
      tick();
      cyc++;
      if (t_req_ack !== 4'b0000) acks++;
      if (t_tx_send) high++;
      else if (high > 0) fell = 1'b1;
    end
    checks++;
    if (!fell || high != 50) begin failures++; $display("FAIL timeout send_len: got %0d cycles (fell %0d) expected 50", high, fell); end
    checks++;
    if (t_err !== 1'b1) begin failures++; $display("FAIL timeout err: got %b expected 1", t_err); end
    checks++;
    if (t_tx_data !== 8'h5A) begin failures++; $display("FAIL timeout tx_data: got %h expected 5a", t_tx_data); end
    t_req           = 4'b0011;
    t_req_data[15:8] = 8'hC3;
    t_req_last      = 4'b0011;
    cyc = 0; rose = 1'b0;
    while (!rose && cyc < 20) begin
      tick();
      cyc++;
      if (t_req_ack !== 4'b0000) acks++;
      rose = t_tx_send;
    end
    checks++;
    if (!rose || t_grant_id !== 2'd1 || t_tx_data !== 8'hC3) begin
      failures++;
      $display("FAIL timeout rr_advance: got rose %0d grant %0d data %h expected grant 1 data c3", rose, t_grant_id, t_tx_data);
    end
    cyc = 0;
    while (t_tx_send && cyc < 100) begin
      tick();
      cyc++;
      if (t_req_ack !== 4'b0000) acks++;
    end
    repeat (5) begin
      tick();
      if (t_req_ack !== 4'b0000) acks++;
    end
    checks++;
    if (t_err !== 1'b1 || acks != 0) begin
      failures++;
      $display("FAIL timeout sticky: got err %b acks %0d expected err 1 acks 0", t_err, acks);
    end
    t_req = 4'b0000;
    t_rst = 1'b1;
    tick();
    t_rst = 1'b0;
    checks++;
    if (t_err !== 1'b0 || t_tx_send !== 1'b0) begin
      failures++;
      $display("FAIL timeout err_clear: got err %b send %b expected 0/0", t_err, t_tx_send);
    end
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    int acks;
    do_reset();
    done_lat  = 0;
    done_hold = 0;
    push_item(1, 8'h77, 1'b1);
    drive_reqs();
    cyc = 0; acks = 0;
    while (!tx_send && cyc < 20) begin tick(); cyc++; end
    repeat (100) begin
      tick();
      if (req_ack !== 4'b0000) acks++;
    end
    checks++;
    if (tx_send !== 1'b1) begin failures++; $display("FAIL rst_mid in_send: got tx_send %b expected 1", tx_send); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (req_ack !== 4'b0000) acks++;
    checks++;
    if (tx_send !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || acks != 0) begin
      failures++;
      $display("FAIL rst_mid outputs: got send %b busy %b err %b acks %0d expected 0/0/0/0", tx_send, busy, err, acks);
    end
    m_rr   = 0;
    m_lock = 1'b0;
    grant_log.delete();
    byte_log.delete();
    done_lat = 5;
    run_traffic("rst_resume", 1, 200);
    checks++;
    if (byte_log.size() != 1 || byte_log[0] !== 8'h77) begin
      failures++;
      $display("FAIL rst_mid resume: got %0d frames byte %h expected 1 frame byte 77", byte_log.size(), byte_log[0]);
    end
  endtask

  task automatic test_done_hold();
    int         cyc;
    int         rises;
    int         hold_cyc;
    int         bad;
    int         acks;
    int         gap;
    bit         after_fall;
    logic       prev_send;
    logic [3:0] ack_val;
    do_reset();
    done_lat  = 8;
    done_hold = 5;
    push_item(0, 8'h3C, 1'b1);
    push_item(1, 8'hC3, 1'b1);
    drive_reqs();
    cyc = 0; rises = 0; hold_cyc = 0; bad = 0; acks = 0; gap = -1;
    after_fall = 1'b0; prev_send = 1'b0; ack_val = 4'b0000;
    while (rises < 2 && cyc < 500) begin
      tick();
      cyc++;
      if (after_fall && done_at_edge) begin
        hold_cyc++;
        if (!busy || tx_send) bad++;
      end
      if (prev_send && !tx_send) after_fall = 1'b1;
      if (!prev_send && tx_send) begin
        rises++;
        after_fall = 1'b0;
        if (rises == 2) gap = since_fall;
      end
      if (req_ack !== 4'b0000) begin
        acks++;
        ack_val = req_ack;
        void'(q[0].pop_front());
        drive_reqs();
      end
      prev_send = tx_send;
    end
    checks++;
    if (hold_cyc != 5 || bad != 0) begin
      failures++;
      $display("FAIL done_hold release: got %0d held cycles with %0d not busy expected 5 and 0", hold_cyc, bad);
    end
    checks++;
    if (rises != 2 || gap < 2) begin
      failures++;
      $display("FAIL done_hold restart: got %0d frames, rise %0d cycles after done fell expected >=2", rises, gap);
    end
    checks++;
    if (acks != 1 || ack_val !== 4'b0001 || grant_id !== 2'd1) begin
      failures++;
      $display("FAIL done_hold ack: got %0d acks value %b next grant %0d expected 1 ack 0001 grant 1", acks, ack_val, grant_id);
    end
  endtask

  task automatic test_req_drop();
    int   cyc;
    int   acks;
    int   resend;
    logic [3:0] ack_val;
    bit   moved;
    do_reset();
    done_lat  = 12;
    done_hold = 0;
    req      = 4'b1000;
    req_data = 32'h9900_0000;
    req_last = 4'b1000;
    cyc = 0;
    while (!tx_send && cyc < 20) begin tick(); cyc++; end
    checks++;
    if (tx_send !== 1'b1 || grant_id !== 2'd3) begin
      failures++;
      $display("FAIL req_drop start: got send %b grant %0d expected 1 and 3", tx_send, grant_id);
    end
    req      = 4'b0000;
    req_data = 32'h0;
    req_last = 4'b0000;
    cyc = 0; acks = 0; ack_val = 4'b0000; moved = 1'b0;
    while (acks == 0 && cyc < 50) begin
      tick();
      cyc++;
      if (tx_send && tx_data !== 8'h99) moved = 1'b1;
      if (req_ack !== 4'b0000) begin acks++; ack_val = req_ack; end
    end
    checks++;
    if (ack_val !== 4'b1000 || moved) begin
      failures++;
      $display("FAIL req_drop ack: got ack %b data moved %0d expected 1000 and 0", ack_val, moved);
    end
    resend = 0;
    repeat (20) begin
      tick();
      if (tx_send) resend++;
      if (req_ack !== 4'b0000) acks++;
    end
    checks++;
    if (resend != 0 || acks != 1) begin
      failures++;
      $display("FAIL req_drop quiet: got %0d send cycles %0d acks expected 0 and 1", resend, acks);
    end
  endtask

  task automatic test_random();
    int nmsg;
    int len;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      done_lat  = $urandom_range(1, 15);
      done_hold = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) begin
        nmsg = $urandom_range(0, 3);
        for (int m = 0; m < nmsg; m++) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) push_item(i, 8'($urandom), (b == len - 1));
        end
      end
      drive_reqs();
      run_traffic("random", 1000, 5000);
      checks++;
      if (pending() != 0) begin
        failures++;
        $display("FAIL random drain round %0d: got %0d bytes left expected 0", r, pending());
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    req        = 4'b0000;
    req_data   = 32'h0;
    req_last   = 4'b0000;
    tx_done    = 1'b0;
    t_rst      = 1'b1;
    t_req      = 4'b0000;
    t_req_data = 32'h0;
    t_req_last = 4'b0000;
    t_tx_done  = 1'b0;
    done_lat   = 0;
    done_hold  = 0;
    send_cnt   = 0;
    hold_cnt   = 0;
    since_fall = 99;
    done_at_edge = 1'b0;

    test_reset();
    test_single_byte();
    test_round_robin();
    test_message_lock();
    test_timeout();
    test_reset_mid_frame();
    test_done_hold();
    test_req_drop();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
